// File: rtl/regbank_mp.sv
// rtl/regbank_mp.sv - multi-port register file with write bypass, hold/clear and busy scoreboard
module regbank_mp #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 4,
    parameter int NRD      = 2,
    parameter int NWR      = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NRD*ADDR_W-1:0] rd_addr,
    input  logic                  hold,
    input  logic                  clear,
    output logic [NRD*DATA_W-1:0] rd_data,
    output logic [NRD-1:0]        rd_busy,
    input  logic [NWR-1:0]        wr_en,
    input  logic [NWR*ADDR_W-1:0] wr_addr,
    input  logic [NWR*DATA_W-1:0] wr_data,
    input  logic                  claim_en,
    input  logic [ADDR_W-1:0]     claim_addr
);

    localparam int NREGS = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [NREGS];
    logic [NREGS-1:0]  busy;
    logic [NREGS-1:0]  busy_next;
    logic [NRD*DATA_W-1:0] rd_cand;
    logic [NRD-1:0]        busy_cand;

    // Array has no reset; later ports overwrite earlier ones so the highest index wins.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int q = 0; q < NWR; q++) begin
                if (wr_en[q] && !(ZERO_REG != 0 && wr_addr[q*ADDR_W +: ADDR_W] == '0))
                    mem[wr_addr[q*ADDR_W +: ADDR_W]] <= wr_data[q*DATA_W +: DATA_W];
            end
        end
    end

    // Claim is applied after the write releases so a same-cycle re-claim keeps the bit set.
    always_comb begin
        busy_next = busy;
        for (int q = 0; q < NWR; q++) begin
            if (wr_en[q])
                busy_next[wr_addr[q*ADDR_W +: ADDR_W]] = 1'b0;
        end
        if (claim_en)
            busy_next[claim_addr] = 1'b1;
        if (ZERO_REG != 0)
            busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset)
            busy <= '0;
        else
            busy <= busy_next;
    end

    always_comb begin
        rd_cand   = '0;
        busy_cand = '0;
        for (int p = 0; p < NRD; p++) begin
            rd_cand[p*DATA_W +: DATA_W] = mem[rd_addr[p*ADDR_W +: ADDR_W]];
            for (int q = 0; q < NWR; q++) begin
                if (wr_en[q] && wr_addr[q*ADDR_W +: ADDR_W] == rd_addr[p*ADDR_W +: ADDR_W])
                    rd_cand[p*DATA_W +: DATA_W] = wr_data[q*DATA_W +: DATA_W];
            end
            busy_cand[p] = busy_next[rd_addr[p*ADDR_W +: ADDR_W]];
            if (ZERO_REG != 0 && rd_addr[p*ADDR_W +: ADDR_W] == '0) begin
                rd_cand[p*DATA_W +: DATA_W] = '0;
                busy_cand[p]                = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            rd_data <= '0;
            rd_busy <= '0;
        end else if (!hold) begin
            rd_data <= rd_cand;
            rd_busy <= busy_cand;
        end
    end

endmodule

// File: tb/tb_regbank_mp.sv
// tb/tb_regbank_mp.sv - self-checking bench for regbank_mp
module tb_regbank_mp;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rd_addr;
    logic        hold;
    logic        clear;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic [1:0]  wr_en;
    logic [7:0]  wr_addr;
    logic [63:0] wr_data;
    logic        claim_en;
    logic [3:0]  claim_addr;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    logic [31:0] m_mem [16];
    bit   [15:0] m_busy;
    logic [31:0] exp_data [2];
    bit          exp_busy [2];

    regbank_mp dut (
        .clk(clk), .reset(reset), .rd_addr(rd_addr), .hold(hold), .clear(clear),
        .rd_data(rd_data), .rd_busy(rd_busy), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .claim_en(claim_en), .claim_addr(claim_addr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Model: outputs are the post-edge register contents / busy bits at the read address.
    task automatic step();
        logic [31:0] nm [16];
        bit   [15:0] nb;
        logic [31:0] nd [2];
        bit          nbz [2];
        nm = m_mem;
        nb = m_busy;
        nd = exp_data;
        nbz = exp_busy;
        if (reset) begin
            nb = '0;
            for (int p = 0; p < 2; p++) begin nd[p] = 0; nbz[p] = 0; end
        end else begin
            for (int q = 0; q < 2; q++) begin
                if (wr_en[q]) begin
                    nb[wr_addr[q*4 +: 4]] = 0;
                    if (wr_addr[q*4 +: 4] != 0) nm[wr_addr[q*4 +: 4]] = wr_data[q*32 +: 32];
                end
            end
            if (claim_en) nb[claim_addr] = 1;
            nb[0] = 0;
            for (int p = 0; p < 2; p++) begin
                if (clear) begin
                    nd[p] = 0; nbz[p] = 0;
                end else if (!hold) begin
                    if (rd_addr[p*4 +: 4] == 0) begin
                        nd[p] = 0; nbz[p] = 0;
                    end else begin
                        nd[p]  = nm[rd_addr[p*4 +: 4]];
                        nbz[p] = nb[rd_addr[p*4 +: 4]];
                    end
                end
            end
        end
        @(posedge clk);
        m_mem = nm;
        m_busy = nb;
        exp_data = nd;
        exp_busy = nbz;
        #1;
    endtask

    task automatic idle();
        wr_en = 0; claim_en = 0; hold = 0; clear = 0;
    endtask

    task automatic wr(input int port, input logic [3:0] a, input logic [31:0] d);
        wr_en[port] = 1'b1;
        wr_addr[port*4 +: 4] = a;
        wr_data[port*32 +: 32] = d;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            for (int p = 0; p < 2; p++) begin
                check($sformatf("model_rd_data_p%0d", p), rd_data[p*32 +: 32], exp_data[p]);
                check($sformatf("model_rd_busy_p%0d", p), {31'b0, rd_busy[p]}, {31'b0, exp_busy[p]});
            end
        end
    end

    initial begin
        for (int i = 0; i < 16; i++) m_mem[i] = 0;
        m_busy = 0;
        exp_data[0] = 0; exp_data[1] = 0; exp_busy[0] = 0; exp_busy[1] = 0;
        reset = 1; rd_addr = 0; wr_addr = 0; wr_data = 0; claim_addr = 0;
        idle();
        step(); step();
        check("reset_rd_data", rd_data[31:0] | rd_data[63:32], 32'h0);
        check("reset_rd_busy", {30'b0, rd_busy}, 32'h0);
        reset = 0;

        // Load every register with a known value so the model is exact.
        for (int i = 0; i < 8; i++) begin
            idle();
            wr(0, 4'(2*i), 32'hA000_0000 + 32'(2*i));
            wr(1, 4'(2*i+1), 32'hA000_0000 + 32'(2*i+1));
            step();
        end
        idle();
        step();
        chk_en = 1;

        // Basic write then read on the other port
        wr(0, 4'd5, 32'hDEADBEEF); step();
        idle(); rd_addr = {4'd5, 4'd1}; step();
        check("basic_rd_data_p1", rd_data[63:32], 32'hDEADBEEF);
        check("basic_rd_busy_p1", {31'b0, rd_busy[1]}, 32'h0);

        // Same-address writes on both ports, bypassed to read port 0
        wr(0, 4'd3, 32'h11); wr(1, 4'd3, 32'h22); rd_addr = {4'd0, 4'd3}; step();
        check("bypass_prio", rd_data[31:0], 32'h22);
        idle(); step();
        check("array_prio", rd_data[31:0], 32'h22);

        // Hardwired zero register
        wr(0, 4'd0, 32'h55); step();
        idle(); rd_addr = 8'h00; step();
        check("zero_data", rd_data[31:0], 32'h0);
        claim_en = 1; claim_addr = 0; step();
        check("zero_busy", {31'b0, rd_busy[0]}, 32'h0);

        // Hold and clear
        idle(); wr(0, 4'd7, 32'h7); step();
        idle(); rd_addr = {4'd7, 4'd7}; step();
        check("hold_pre", rd_data[31:0], 32'h7);
        hold = 1; wr(1, 4'd7, 32'h9); step();
        check("hold_1", rd_data[31:0], 32'h7);
        wr_en = 0; step();
        check("hold_2", rd_data[63:32], 32'h7);
        hold = 0; step();
        check("hold_release", rd_data[31:0], 32'h9);
        clear = 1; step();
        check("clear", rd_data[31:0] | rd_data[63:32], 32'h0);
        clear = 0;

        // Scoreboard
        claim_en = 1; claim_addr = 4; rd_addr = {4'd4, 4'd4}; step();
        check("sb_claim", {31'b0, rd_busy[0]}, 32'h1);
        wr(0, 4'd4, 32'h44); step();
        check("sb_reclaim", {31'b0, rd_busy[1]}, 32'h1);
        claim_en = 0; wr(1, 4'd4, 32'h45); wr_en[0] = 0; step();
        check("sb_release", {31'b0, rd_busy[0]}, 32'h0);
        check("sb_release_data", rd_data[31:0], 32'h45);

        // Reset mid-operation
        idle(); claim_en = 1; claim_addr = 2; step();
        idle(); rd_addr = {4'd2, 4'd6}; step();
        check("pre_reset_busy", {31'b0, rd_busy[1]}, 32'h1);
        reset = 1; wr(0, 4'd6, 32'h33); claim_en = 1; claim_addr = 5; step();
        check("rst_data", rd_data[31:0] | rd_data[63:32], 32'h0);
        check("rst_busy", {30'b0, rd_busy}, 32'h0);
        reset = 0; idle(); step();
        check("rst_r6_kept", rd_data[31:0], 32'hA000_0006);
        check("rst_busy_r2", {31'b0, rd_busy[1]}, 32'h0);
        rd_addr = {4'd3, 4'd5}; step();
        check("rst_r5_kept", rd_data[31:0], 32'hDEADBEEF);
        check("rst_busy_r5", {31'b0, rd_busy[0]}, 32'h0);

        // Mixed traffic against the model only
        for (int i = 0; i < 60; i++) begin
            wr_en      = 2'($urandom_range(0, 3));
            wr_addr    = 8'($urandom);
            wr_data    = {$urandom, $urandom};
            claim_en   = 1'($urandom);
            claim_addr = 4'($urandom);
            rd_addr    = (i % 4 == 0) ? {wr_addr[7:4], claim_addr} : 8'($urandom);
            hold       = ($urandom_range(0, 7) == 0);
            clear      = ($urandom_range(0, 11) == 0);
            reset      = ($urandom_range(0, 29) == 0);
            step();
        end
        reset = 0; idle(); step();
        @(negedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
